fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller for the 16-bit WISC core. Owns the architectural fetch PC and sequences requests to instruction memory. Accepts redirects from the ID-stage branch resolver (`PC_control` `PC_out` when `branchTaken`=1) and stalls from the hazard unit, and stops fetching on HLT. Sits between instruction memory and the IF/ID pipeline register, which it drives directly.

## Interface
- `RESET_PC`, 16'h0000, fetch address after reset
- `HLT_OPCODE`, 4'hF, opcode (`instr[15:12]`) that ends fetch
- `clk` in 1: the single clock; all state is updated on its rising edge
- `rst` in 1: reset, asynchronous and active-high
- `imem_req` out 1: fetch request; level-held until `imem_ready`
- `imem_addr` out 16: fetch address; stable while `imem_req`=1
- `imem_ready` in 1: `imem_data` valid this cycle; completes the request
- `imem_data` in 16: fetched instruction
- `stall` in 1: hold IF/ID outputs
- `redirect_valid` in 1: taken branch resolved in ID
- `redirect_pc` in 16: branch target; bit 0 forced to 0
- `if_valid` out 1: `if_instr` and `if_pc` are a live instruction
- `if_instr` out 16: instruction to IF/ID
- `if_pc` out 16: address of `if_instr`
- `flush` out 1: one-cycle pulse after a redirect is accepted; IF/ID squash
- `halted` out 1: HLT delivered; fetch stopped

## Operation
- Registers:
  - `pc` (16 bits)
  - `state`: FETCH, DRAIN, SKID, HALT
  - skid buffer: instr, pc
  - IF outputs
- Reset values:
  - `pc`=`RESET_PC`, `state`=FETCH.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `if_valid`=0, `if_instr`=16'h0000, `if_pc`=16'h0000.
  - `flush`=0, `halted`=0.
  - `imem_req` is forced 0 combinationally while `rst`=1.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. On an edge with `imem_ready`=1:
  - `pc`←`pc`+2, modulo 2^16, so 16'hFFFE wraps to 16'h0000. `pc` does not advance if the data is HLT.
  - If `stall`=0: IF outputs ← {1, `imem_data`, `pc`}. If the data is HLT, go to HALT.
  - If `stall`=1: skid ← data; go to SKID.
- FETCH with `imem_ready`=0 and `stall`=0: `if_valid`←0 (bubble).
- Any state with `stall`=1: IF outputs hold their values.
- SKID:
  - `imem_req`=0.
  - When `stall`=0: IF outputs ← {1, skid}. Go to HALT if the skid holds HLT, else go to FETCH.
- HALT:
  - `imem_req`=0, `halted`=1, `pc` holds the HLT address.
  - IF outputs: `if_valid`←0 once `stall`=0.
- Redirect: on an edge with `redirect_valid`=1, the redirect beats `stall`, skid contents and HLT detection.
  - `pc`←{`redirect_pc`[15:1], 0}.
  - `if_valid`←0, skid discarded, `flush`←1 for one cycle, `halted`←0.
  - Next state is FETCH, except DRAIN when `imem_req`=1 and `imem_ready`=0 in that cycle.
- DRAIN:
  - `imem_req` stays 1, `imem_addr` keeps the old address.
  - On `imem_ready`: data discarded, go to FETCH.
  - A further redirect during DRAIN only updates `pc`.
- Simultaneous `redirect_valid` and `imem_ready`: the data is discarded, no DRAIN, and the HLT in that data is ignored.
- Exit from HALT is by reset or redirect only, because a speculative HLT behind a taken branch must be cancelled.

## Timing
- Zero-wait memory (`imem_ready`=1 every cycle): one instruction per cycle. A request in cycle N produces `if_valid`=1 in cycle N+1.
- Redirect sampled at edge N:
  - `imem_addr`=target in cycle N+1.
  - The target instruction is in IF at cycle N+2 at earliest.
  - `flush`=1 during cycle N+1 only.
- Wait states extend FETCH or DRAIN one cycle each. There is no timeout.
- `stall` is sampled at the edge and has no combinational path to `imem_req` except through `state`.
- `imem_addr` equals `pc` in every state except DRAIN.

## Structure
- `wisc_pkg`: `OP_HLT`=4'hF, `RESET_PC`, fetch-state enum.
- Sub-module `fetch_skid_buf`: one-entry {instr, pc} holder with load/clear/valid. The FSM, `pc` register and output registers live in `fetch_sequencer`.

## Test plan
- Reset, then `imem_ready`=1 with data 0x1000, 0x2000, 0x3000 → `if_pc` 0x0000, 0x0002, 0x0004 on consecutive cycles; `imem_addr` is 0x0000 in the first cycle after reset.
- `stall`=1 for 3 cycles with `imem_ready`=1 → one word goes to the skid, `imem_req` drops, IF outputs are unchanged; on release the skid word appears, then fetch resumes at +2.
- Request at 0x0010 with `imem_ready` late by 2 cycles and `redirect_valid`/`redirect_pc`=0x0101 in the first wait cycle → DRAIN holds `imem_addr`=0x0010, the returned data is dropped, the next request is 0x0100, and `flush` pulses once.
- Data 0xF000 fetched at 0x0020 → `if_instr`=0xF000, `halted`=1, `imem_req`=0 forever; a later redirect to 0x0040 clears `halted` and fetches 0x0040.
- `redirect_valid`, `stall` and `imem_ready` (data 0xF000) in the same cycle → no halt, `if_valid`=0, next `imem_addr`=target.
- `pc` 0xFFFE accepted → next `imem_addr`=0x0000; `rst` asserted mid-wait → `imem_req`=0 immediately.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wisc_pkg
//  Description : Shared constants, fetch-state encoding and opcode helper
//                for the WISC instruction-fetch sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package wisc_pkg;

  localparam logic [3:0]  OP_HLT   = 4'hF;
  localparam logic [15:0] RESET_PC = 16'h0000;

  // Fetch controller states
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // requesting imem at pc
    ST_DRAIN = 2'd1,  // waiting out a request orphaned by a redirect
    ST_SKID  = 2'd2,  // one fetched word parked behind a stall
    ST_HALT  = 2'd3   // HLT delivered, fetch stopped
  } fetch_state_t;

  // True when the instruction word carries the given halt opcode
  function automatic logic is_hlt(input logic [15:0] instr, input logic [3:0] opcode);
    return (instr[15:12] == opcode);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer_if
//  Description : Instruction-memory, hazard/branch and IF/ID signals of the
//                fetch sequencer. master = sequencer, slave = surroundings.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        flush;
  logic        halted;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_data,
    input  stall, redirect_valid, redirect_pc,
    output if_valid, if_instr, if_pc, flush, halted
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_data,
    output stall, redirect_valid, redirect_pc,
    input  if_valid, if_instr, if_pc, flush, halted
  );

endinterface
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid_buf
//  Description : One-entry {instr, pc} holder that catches a fetched word
//                arriving while the IF/ID register is stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        i_load,
  input  wire logic        i_clear,
  input  wire logic [15:0] i_instr,
  input  wire logic [15:0] i_pc,
  output logic             o_valid,
  output logic [15:0]      o_instr,
  output logic [15:0]      o_pc
);

  logic        r_valid;
  logic [15:0] r_instr;
  logic [15:0] r_pc;

  // Capture on load; clear (redirect or hand-off) wins over load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= 16'h0000;
      r_pc    <= 16'h0000;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : WISC instruction-fetch controller. Owns the fetch PC,
//                issues level-held imem requests, parks a word in a skid
//                buffer on stall, drains orphaned requests after a redirect
//                and stops fetching on HLT until redirect or reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC   = wisc_pkg::RESET_PC,
  parameter logic [3:0]  HLT_OPCODE = wisc_pkg::OP_HLT
) (
  input wire logic          clk,
  input wire logic          rst,
  fetch_sequencer_if.master bus
);

  import wisc_pkg::*;

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic [15:0] r_pc;
  logic [15:0] w_pc_nxt;
  logic [15:0] r_drain_addr;
  logic        r_if_valid;
  logic [15:0] r_if_instr;
  logic [15:0] r_if_pc;
  logic        r_flush;

  logic        w_if_valid_nxt;
  logic [15:0] w_if_instr_nxt;
  logic [15:0] w_if_pc_nxt;
  logic        w_skid_load;
  logic        w_skid_clear;
  logic        w_drain_load;
  logic        w_req_state;
  logic        w_data_hlt;
  logic        w_skid_valid;
  logic [15:0] w_skid_instr;
  logic [15:0] w_skid_pc;
  logic [15:0] w_redirect_target;

  // Request is a pure function of state so stall never reaches imem_req directly
  assign w_req_state       = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  assign w_data_hlt        = is_hlt(bus.imem_data, HLT_OPCODE);
  assign w_redirect_target = bus.redirect_pc & 16'hFFFE;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_instr (bus.imem_data),
    .i_pc    (r_pc),
    .o_valid (w_skid_valid),
    .o_instr (w_skid_instr),
    .o_pc    (w_skid_pc)
  );

  // Next-state, next-pc and IF-output decisions; redirect overrides everything
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_if_valid_nxt = r_if_valid;
    w_if_instr_nxt = r_if_instr;
    w_if_pc_nxt    = r_if_pc;
    w_skid_load    = 1'b0;
    w_skid_clear   = 1'b0;
    w_drain_load   = 1'b0;

    if (bus.redirect_valid) begin
      w_pc_nxt       = w_redirect_target;
      w_if_valid_nxt = 1'b0;
      w_skid_clear   = 1'b1;
      if (w_req_state && !bus.imem_ready) begin
        // An outstanding request must still complete; remember its address
        w_state_nxt  = ST_DRAIN;
        w_drain_load = (r_state == ST_FETCH);
      end else begin
        w_state_nxt  = ST_FETCH;
      end
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (bus.imem_ready) begin
            if (!w_data_hlt) begin
              w_pc_nxt = r_pc + 16'd2;
            end
            if (!bus.stall) begin
              w_if_valid_nxt = 1'b1;
              w_if_instr_nxt = bus.imem_data;
              w_if_pc_nxt    = r_pc;
              if (w_data_hlt) begin
                w_state_nxt = ST_HALT;
              end
            end else begin
              w_skid_load = 1'b1;
              w_state_nxt = ST_SKID;
            end
          end else if (!bus.stall) begin
            w_if_valid_nxt = 1'b0;
          end
        end
        ST_SKID: begin
          if (!bus.stall && w_skid_valid) begin
            w_if_valid_nxt = 1'b1;
            w_if_instr_nxt = w_skid_instr;
            w_if_pc_nxt    = w_skid_pc;
            w_skid_clear   = 1'b1;
            w_state_nxt    = is_hlt(w_skid_instr, HLT_OPCODE) ? ST_HALT : ST_FETCH;
          end
        end
        ST_HALT: begin
          if (!bus.stall) begin
            w_if_valid_nxt = 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!bus.stall) begin
            w_if_valid_nxt = 1'b0;
          end
          if (bus.imem_ready) begin
            w_state_nxt = ST_FETCH;
          end
        end
        default: begin
          w_state_nxt = ST_FETCH;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fetch PC and the address held for a draining request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_drain_addr <= RESET_PC;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_drain_load) begin
        r_drain_addr <= r_pc;
      end
    end
  end

  // IF/ID outputs and the one-cycle flush pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_valid <= 1'b0;
      r_if_instr <= 16'h0000;
      r_if_pc    <= 16'h0000;
      r_flush    <= 1'b0;
    end else begin
      r_if_valid <= w_if_valid_nxt;
      r_if_instr <= w_if_instr_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_flush    <= bus.redirect_valid;
    end
  end

  assign bus.imem_req  = w_req_state && !rst;
  assign bus.imem_addr = (r_state == ST_DRAIN) ? r_drain_addr : r_pc;
  assign bus.if_valid  = r_if_valid;
  assign bus.if_instr  = r_if_instr;
  assign bus.if_pc     = r_if_pc;
  assign bus.flush     = r_flush;
  assign bus.halted    = (r_state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Directed self-checking bench for fetch_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  fetch_sequencer_if u_if ();

  fetch_sequencer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    u_if.imem_ready     = 1'b0;
    u_if.imem_data      = 16'h0000;
    u_if.stall          = 1'b0;
    u_if.redirect_valid = 1'b0;
    u_if.redirect_pc    = 16'h0000;

    // Reset state
    step();
    step();
    chk("rst_req",    {15'd0, u_if.imem_req}, 16'h0000);
    chk("rst_addr",   u_if.imem_addr,         16'h0000);
    chk("rst_valid",  {15'd0, u_if.if_valid}, 16'h0000);
    chk("rst_instr",  u_if.if_instr,          16'h0000);
    chk("rst_ifpc",   u_if.if_pc,             16'h0000);
    chk("rst_flush",  {15'd0, u_if.flush},    16'h0000);
    chk("rst_halted", {15'd0, u_if.halted},   16'h0000);

    rst = 1'b0;
    #1;
    chk("post_rst_req",  {15'd0, u_if.imem_req}, 16'h0001);
    chk("post_rst_addr", u_if.imem_addr,         16'h0000);

    // Zero-wait streaming
    u_if.imem_ready = 1'b1;
    u_if.imem_data  = 16'h1000;
    step();
    chk("s0_valid", {15'd0, u_if.if_valid}, 16'h0001);
    chk("s0_instr", u_if.if_instr,          16'h1000);
    chk("s0_ifpc",  u_if.if_pc,             16'h0000);
    chk("s0_addr",  u_if.imem_addr,         16'h0002);
    u_if.imem_data = 16'h2000;
    step();
    chk("s1_instr", u_if.if_instr, 16'h2000);
    chk("s1_ifpc",  u_if.if_pc,    16'h0002);
    u_if.imem_data = 16'h3000;
    step();
    chk("s2_instr", u_if.if_instr, 16'h3000);
    chk("s2_ifpc",  u_if.if_pc,    16'h0004);
    chk("s2_addr",  u_if.imem_addr, 16'h0006);

    // Stall for three cycles: word at 0x0006 parks in the skid
    u_if.stall     = 1'b1;
    u_if.imem_data = 16'h4000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_req",   {15'd0, u_if.imem_req}, 16'h0000);
      chk("stall_ifpc",  u_if.if_pc,             16'h0004);
      chk("stall_instr", u_if.if_instr,          16'h3000);
      chk("stall_valid", {15'd0, u_if.if_valid}, 16'h0001);
    end
    u_if.stall = 1'b0;
    step();
    chk("skid_ifpc",  u_if.if_pc,             16'h0006);
    chk("skid_instr", u_if.if_instr,          16'h4000);
    chk("skid_req",   {15'd0, u_if.imem_req}, 16'h0001);
    chk("skid_addr",  u_if.imem_addr,         16'h0008);
    u_if.imem_data = 16'h5000;
    step();
    chk("resume_ifpc",  u_if.if_pc,     16'h0008);
    chk("resume_instr", u_if.if_instr,  16'h5000);
    chk("resume_addr",  u_if.imem_addr, 16'h000A);

    // Redirect to 0x0010 together with ready: data dropped, no drain
    u_if.imem_data      = 16'h6000;
    u_if.redirect_valid = 1'b1;
    u_if.redirect_pc    = 16'h0010;
    step();
    chk("rd1_flush", {15'd0, u_if.flush},    16'h0001);
    chk("rd1_valid", {15'd0, u_if.if_valid}, 16'h0000);
    chk("rd1_addr",  u_if.imem_addr,         16'h0010);

    // First wait cycle at 0x0010 carries a redirect to 0x0101 -> DRAIN
    u_if.imem_ready  = 1'b0;
    u_if.redirect_pc = 16'h0101;
    step();
    chk("dr_addr0",  u_if.imem_addr,         16'h0010);
    chk("dr_req0",   {15'd0, u_if.imem_req}, 16'h0001);
    chk("dr_flush0", {15'd0, u_if.flush},    16'h0001);
    u_if.redirect_valid = 1'b0;
    step();
    chk("dr_addr1",  u_if.imem_addr,         16'h0010);
    chk("dr_flush1", {15'd0, u_if.flush},    16'h0000);
    u_if.imem_ready = 1'b1;
    u_if.imem_data  = 16'h7000;
    step();
    chk("dr_done_addr",  u_if.imem_addr,         16'h0100);
    chk("dr_done_valid", {15'd0, u_if.if_valid}, 16'h0000);

    // HLT at 0x0020
    u_if.redirect_valid = 1'b1;
    u_if.redirect_pc    = 16'h0020;
    step();
    chk("h_addr", u_if.imem_addr, 16'h0020);
    u_if.redirect_valid = 1'b0;
    u_if.imem_data      = 16'hF000;
    step();
    chk("h_instr",  u_if.if_instr,          16'hF000);
    chk("h_ifpc",   u_if.if_pc,             16'h0020);
    chk("h_halted", {15'd0, u_if.halted},   16'h0001);
    chk("h_req",    {15'd0, u_if.imem_req}, 16'h0000);
    step();
    step();
    chk("h2_req",    {15'd0, u_if.imem_req}, 16'h0000);
    chk("h2_valid",  {15'd0, u_if.if_valid}, 16'h0000);
    chk("h2_addr",   u_if.imem_addr,         16'h0020);
    chk("h2_halted", {15'd0, u_if.halted},   16'h0001);
    u_if.imem_ready     = 1'b0;
    u_if.redirect_valid = 1'b1;
    u_if.redirect_pc    = 16'h0040;
    step();
    chk("hx_halted", {15'd0, u_if.halted},   16'h0000);
    chk("hx_req",    {15'd0, u_if.imem_req}, 16'h0001);
    chk("hx_addr",   u_if.imem_addr,         16'h0040);
    u_if.redirect_valid = 1'b0;
    u_if.imem_ready     = 1'b1;
    u_if.imem_data      = 16'h1234;
    step();
    chk("hx_ifpc",  u_if.if_pc,    16'h0040);
    chk("hx_instr", u_if.if_instr, 16'h1234);

    // Redirect + stall + ready with HLT data in the same cycle
    u_if.redirect_valid = 1'b1;
    u_if.redirect_pc    = 16'h0080;
    u_if.stall          = 1'b1;
    u_if.imem_data      = 16'hF000;
    step();
    chk("combo_halted", {15'd0, u_if.halted},   16'h0000);
    chk("combo_valid",  {15'd0, u_if.if_valid}, 16'h0000);
    chk("combo_addr",   u_if.imem_addr,         16'h0080);
    chk("combo_req",    {15'd0, u_if.imem_req}, 16'h0001);
    u_if.redirect_valid = 1'b0;
    u_if.stall          = 1'b0;
    u_if.imem_data      = 16'h2222;
    step();
    chk("combo_ifpc", u_if.if_pc, 16'h0080);

    // Odd redirect target forced even, then wrap past 0xFFFE
    u_if.redirect_valid = 1'b1;
    u_if.redirect_pc    = 16'hFFFF;
    step();
    chk("wrap_addr0", u_if.imem_addr, 16'hFFFE);
    u_if.redirect_valid = 1'b0;
    u_if.imem_data      = 16'h3333;
    step();
    chk("wrap_ifpc",  u_if.if_pc,     16'hFFFE);
    chk("wrap_addr1", u_if.imem_addr, 16'h0000);
    u_if.imem_data = 16'h4444;
    step();
    chk("wrap_addr2", u_if.imem_addr, 16'h0002);

    // Reset asserted in the middle of a wait
    u_if.imem_ready = 1'b0;
    step();
    chk("wait_req",  {15'd0, u_if.imem_req}, 16'h0001);
    chk("wait_addr", u_if.imem_addr,         16'h0002);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req",   {15'd0, u_if.imem_req}, 16'h0000);
    chk("arst_addr",  u_if.imem_addr,         16'h0000);
    chk("arst_valid", {15'd0, u_if.if_valid}, 16'h0000);
    step();
    rst = 1'b0;
    #1;
    chk("rerun_req", {15'd0, u_if.imem_req}, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
